// File: rtl/gabor_pkg.sv
// Shared constants and helpers for the Gabor window streamer: default geometry,
// a constant-safe clog2, and the flattened win_out slice base for element (i,j).
package gabor_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 516;
    localparam int DEF_IMG_H = 516;
    localparam int DEF_K     = 5;

    // Never returns less than 1 so that degenerate sizes still give a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int win_idx(input int i, input int j, input int k, input int pix_w);
        return pix_w * (i * k + j);
    endfunction

endpackage

// File: rtl/gabor_line_buffer.sv
// One image row of delay: dout_o is the pixel pushed DEPTH advances ago.
// Circular RAM with a single pointer; contents are intentionally not reset.
module gabor_line_buffer
    import gabor_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = DEF_IMG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    assign dout_o = mem_q[ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end

    // Read-before-write on the same slot gives exactly DEPTH cycles of delay.
    always_ff @(posedge clk) begin
        if (adv_i) mem_q[ptr_q] <= din_i;
    end

endmodule

// File: rtl/gabor_window_streamer.sv
// Raster pixel stream to KxK sliding window with valid/ready on both sides.
// Optional build macro GABOR_WIN_COORD_EN adds win_row/win_col (top-left of window).
module gabor_window_streamer
    import gabor_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_sof,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [K*K*PIX_W-1:0]   win_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   frame_done,
    output logic                   sof_err
`ifdef GABOR_WIN_COORD_EN
    ,
    output logic [clog2(IMG_H)-1:0] win_row,
    output logic [clog2(IMG_W)-1:0] win_col
`endif
);

    localparam int ROW_W = clog2(IMG_H);
    localparam int COL_W = clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(K - 1);

    logic             accept, win_hit;
    logic [ROW_W-1:0] row_q, row_d, eff_row;
    logic [COL_W-1:0] col_q, col_d, eff_col;
    logic             win_valid_q, win_valid_d;
    logic             last_q, last_d;
    logic             sof_err_q, sof_err_d;
    logic [PIX_W-1:0] chain [K];
    logic [PIX_W-1:0] win_q [K][K];

    assign pix_ready  = !win_valid_q || win_ready;
    assign accept     = pix_valid && pix_ready;
    assign win_valid  = win_valid_q;
    assign sof_err    = sof_err_q;
    assign frame_done = win_valid_q && win_ready && last_q;

    // chain[0] is the incoming (bottom) row; chain[K-1] is the oldest (top) row.
    assign chain[0] = pix_in;
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        gabor_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (accept),
            .din_i  (chain[g]),
            .dout_o (chain[g+1])
        );
    end

    always_comb begin
        eff_row     = pix_sof ? '0 : row_q;
        eff_col     = pix_sof ? '0 : col_q;
        win_hit     = (eff_row >= ROW_K1) && (eff_col >= COL_K1);
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q && !win_ready;
        last_d      = last_q;
        sof_err_d   = 1'b0;
        if (accept) begin
            sof_err_d   = pix_sof && ((row_q != '0) || (col_q != '0));
            win_valid_d = win_hit;
            last_d      = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_d = eff_col + COL_W'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            last_q      <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            last_q      <= last_d;
            sof_err_q   <= sof_err_d;
        end
    end

    // Window columns shift left on every accept; the new column enters at j=K-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win_q[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
                win_q[i][K-1] <= chain[K-1-i];
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign win_out[win_idx(i, j, K, PIX_W) +: PIX_W] = win_q[i][j];
        end
    end

`ifdef GABOR_WIN_COORD_EN
    logic [ROW_W-1:0] win_row_q;
    logic [COL_W-1:0] win_col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (accept && win_hit) begin
            win_row_q <= eff_row - ROW_K1;
            win_col_q <= eff_col - COL_K1;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

endmodule

// File: doc/gabor_window_streamer.md
Name: gabor_window_streamer

Overview:
- Streaming line-buffer window generator that replaces random-access image fetches feeding conv_unit.
- Accepts one raster-order pixel per handshake and emits a KxK window, flattened, whenever the window is fully inside the frame.
- Generalises the fixed 5x5 / 516-wide fetch: kernel size, pixel width and image dimensions are parameters, and both sides have backpressure.
- Sits between the pixel source (DMA/ROM) and the Gabor convolution array.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 516, pixels per input row (padded width).
- IMG_H, 516, rows per frame.
- K, 5, window size (odd, 3..13).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pix_in  in  PIX_W  input pixel.
- pix_sof  in  1  marks the first pixel of a frame; qualified by pix_valid.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block can accept a pixel.
- win_out  out  K*K*PIX_W  window; element (i,j) at [PIX_W*(i*K+j) +: PIX_W]; i=0 is the top row, j=0 the left column.
- win_valid  out  1  win_out is valid.
- win_ready  in  1  downstream accepts the window.
- frame_done  out  1  one-cycle pulse when the last window of a frame is accepted.
- sof_err  out  1  one-cycle pulse on an unexpected pix_sof.

Behaviour:
- Reset (rst=0, async):
  - win_valid=0, frame_done=0, sof_err=0, win_out=0.
  - Internal col=0 and row=0.
  - Line buffer contents are not cleared; they are don't-care because no window is emitted until K-1 rows have been refilled.
- pix_ready = !win_valid || win_ready. This is a one-deep output register with no combinational path from pix_valid.
- Accept = pix_valid && pix_ready. On accept:
  - The pixel shifts into the window column shift registers.
  - The line buffers (K-1 delay lines, each IMG_W deep) advance.
  - col increments. At col=IMG_W-1, col wraps to 0 and row increments. At row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
- Window emission:
  - If the accepted pixel has row>=K-1 and col>=K-1, win_valid rises on the next edge.
  - win_out then holds rows row-K+1..row and cols col-K+1..col.
  - Latency is 1 clock from acceptance of the bottom-right pixel.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1). The default is 262144.
- Windows never span a row wrap: accepts with col<K-1 do not produce a window.
- Output hold: win_valid and win_out stay stable while win_ready=0. Input stalls in the same state; there is no overwrite and no drop.
- Window accept and new pixel accept in the same cycle is legal and sustains 1 window/clock.
- frame_done pulses in the cycle the final window (row=IMG_H-1, col=IMG_W-1) is accepted (win_valid && win_ready).
- pix_sof handling:
  - pix_sof on an accept with (row,col)=(0,0) is normal.
  - pix_sof on an accept with (row,col)≠(0,0) forces a resync: that pixel is treated as (0,0), sof_err pulses 1 cycle, and no window is emitted until K-1 new rows have arrived.
  - pix_sof is ignored when pix_valid=0.
- Reset mid-frame: any pending window is discarded and the next accepted pixel is (0,0).

Optional Feature:
- GABOR_WIN_COORD_EN defined: adds two outputs.
  - win_row [clog2(IMG_H)] and win_col [clog2(IMG_W)] give the top-left coordinate of the current window, for writing filtered images by address.
  - Both are registered with win_out, reset to 0, and held under stall.
- Undefined: these ports and their counters are absent. Window behaviour is otherwise identical.

Decomposition:
- gabor_pkg holds:
  - localparams for the default PIX_W/K/IMG_W/IMG_H;
  - a clog2 function;
  - an index helper returning the win_out slice base for (i,j).
- Sub-module gabor_line_buffer: parametrised PIX_W x IMG_W delay line with an advance enable. The streamer instantiates K-1 of them, chained.

Test Plan:
- Nominal flow:
  - Stimulus: K=3, IMG_W=8, IMG_H=6, pixel=(16*r+c) mod 256, pix_valid and win_ready always 1.
  - Response: exactly 24 windows; first window center = 0x11, element (0,0)=0x00, element (2,2)=0x22; frame_done pulses once with the 24th window.
- Random backpressure:
  - Stimulus: same frame, win_ready randomly 0 for 1-5 cycles.
  - Response: same 24 windows in order; win_out stable while stalled; pix_ready=0 only when win_valid=1 and win_ready=0.
- Mid-frame resync:
  - Stimulus: pix_sof asserted on pixel (3,2).
  - Response: sof_err pulses once; the next window appears only after 2 further full rows; its coordinates restart from (0,0).
- Async reset mid-frame:
  - Stimulus: rst low for 3 cycles after 20 pixels, then a fresh frame.
  - Response: win_valid drops immediately; output is 24 correct windows.
- Default parameters:
  - Stimulus: the existing 516x516 image file.
  - Response: 262144 windows; each bit-exact to the 25-pixel fetch at top-left address row*516+col.
- GABOR_WIN_COORD_EN build:
  - Stimulus: K=3 frame with the macro defined.
  - Response: win_row/win_col sequence (0,0),(0,1)..(0,5),(1,0)..(3,5).
